// File: rtl/multi_event_sync.sv
// Multi-channel receive-side event synchroniser: per-channel sync chain, programmable
// edge decode, one-cycle event pulse, sticky flag and saturating event counter.
module multi_event_sync #(
   parameter int                          NUM_CHANNELS    = 4,
   parameter int                          NUM_SYNC_STAGES = 2,
   parameter logic [2*NUM_CHANNELS-1:0]   EDGE_MODE       = '0,
   parameter int                          CNT_W           = 8,
   parameter bit                          REGISTER_OUTPUT = 1'b1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_CHANNELS-1:0]       signal_id,
   input  logic [NUM_CHANNELS-1:0]       clr_id,
   output logic [NUM_CHANNELS-1:0]       pulse_od,
   output logic [NUM_CHANNELS-1:0]       sticky_od,
   output logic [NUM_CHANNELS*CNT_W-1:0] cnt_od,
   output logic [NUM_CHANNELS-1:0]       cnt_sat_od
);

   localparam int                ARM_MAX  = NUM_SYNC_STAGES + 1;
   localparam int                ARM_W    = $clog2(ARM_MAX + 1);
   localparam logic [ARM_W-1:0]  ARM_LAST = ARM_W'(ARM_MAX);
   localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

   logic [NUM_CHANNELS-1:0] sync_ff [NUM_SYNC_STAGES];
   logic [NUM_CHANNELS-1:0] sync;
   logic [NUM_CHANNELS-1:0] sync_1d;
   logic [NUM_CHANNELS-1:0] evt;
   logic [NUM_CHANNELS-1:0] pulse_nxt;
   logic [ARM_W-1:0]        arm_cnt;
   logic                    armed;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < NUM_SYNC_STAGES; s++) sync_ff[s] <= '0;
         sync_1d <= '0;
      end else begin
         sync_ff[0] <= signal_id;
         for (int s = 1; s < NUM_SYNC_STAGES; s++) sync_ff[s] <= sync_ff[s-1];
         sync_1d <= sync;
      end
   end

   assign sync = sync_ff[NUM_SYNC_STAGES-1];

   // armed rises the cycle after the counter saturates, so inputs that were already
   // high at reset release (or changed while the chain filled) never raise an event.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         arm_cnt <= '0;
         armed   <= 1'b0;
      end else begin
         if (arm_cnt != ARM_LAST) arm_cnt <= arm_cnt + 1'b1;
         armed <= (arm_cnt == ARM_LAST);
      end
   end

   for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
      localparam logic [1:0] MODE = EDGE_MODE[2*i+1:2*i];

      logic             raw_evt;
      logic [CNT_W-1:0] cnt_q;
      logic [CNT_W-1:0] cnt_base;
      logic [CNT_W-1:0] cnt_nxt;
      logic             sticky_q;
      logic             sat_q;

      always_comb begin
         case (MODE)
            2'd0:    raw_evt = sync[i] ^ sync_1d[i];
            2'd2:    raw_evt = ~sync[i] & sync_1d[i];
            default: raw_evt = sync[i] & ~sync_1d[i];
         endcase
      end

      assign evt[i]       = raw_evt & armed;
      assign pulse_nxt[i] = (MODE == 2'd3) ? (sync[i] & armed) : evt[i];

      // A clear and an event in the same cycle leave the channel at one event.
      assign cnt_base = clr_id[i] ? '0 : cnt_q;
      assign cnt_nxt  = (evt[i] && (cnt_base != CNT_MAX)) ? cnt_base + 1'b1 : cnt_base;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            cnt_q    <= '0;
            sticky_q <= 1'b0;
            sat_q    <= 1'b0;
         end else begin
            cnt_q    <= cnt_nxt;
            sat_q    <= (cnt_nxt == CNT_MAX);
            sticky_q <= evt[i] | (sticky_q & ~clr_id[i]);
         end
      end

      assign cnt_od[CNT_W*i +: CNT_W] = cnt_q;
      assign sticky_od[i]             = sticky_q;
      assign cnt_sat_od[i]            = sat_q;
   end

   if (REGISTER_OUTPUT) begin : g_pulse_reg
      logic [NUM_CHANNELS-1:0] pulse_q;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) pulse_q <= '0;
         else        pulse_q <= pulse_nxt;
      end

      assign pulse_od = pulse_q;
   end else begin : g_pulse_comb
      assign pulse_od = pulse_nxt;
   end

endmodule

// File: doc/multi_event_sync.md
Name: multi_event_sync

Overview:
- Multi-channel receive-side event synchroniser; generalised successor to the single-channel toggle pulse synchroniser.
- Takes NUM_CHANNELS asynchronous level/toggle signals from foreign clock domains and brings them into the clk domain.
- Per channel: a programmable edge mode, a one-cycle event pulse, a sticky flag, and a saturating event counter.
- Sits at the clk-domain boundary of the WXP fabric; the status registers and the interrupt logic consume its outputs.

Parameters:
- NUM_CHANNELS, 4: number of independent channels (1..32).
- NUM_SYNC_STAGES, 2: synchroniser flop depth per channel (legal range 2..4).
- EDGE_MODE, 0: packed 2 bits per channel, channel i at bits [2i+1:2i].
  - 0 = any edge (toggle decode), 1 = rising, 2 = falling, 3 = level.
- CNT_W, 8: event counter width per channel.
- REGISTER_OUTPUT, 1: 1 = pulse_od is registered; 0 = pulse_od is combinational from the edge detect.

Ports:
- clk  in  1  destination clock.
- rst_n  in  1  asynchronous active-low reset.
- signal_id  in  NUM_CHANNELS  asynchronous inputs, one per channel.
- clr_id  in  NUM_CHANNELS  synchronous per-channel clear of the sticky flag and counter.
- pulse_od  out  NUM_CHANNELS  one-cycle event pulse per channel; in level mode it is the synced level.
- sticky_od  out  NUM_CHANNELS  set on event, held until cleared.
- cnt_od  out  NUM_CHANNELS*CNT_W  packed event counts, channel i at [CNT_W*(i+1)-1:CNT_W*i].
- cnt_sat_od  out  NUM_CHANNELS  channel counter is at its maximum, 2^CNT_W-1.

Behaviour:
- Reset:
  - Single clock; reset is asynchronous and active-low.
  - All synchroniser flops, history flops, pulse_od, sticky_od, cnt_od and cnt_sat_od reset to 0.
  - The arm counter resets to 0.
- Sync chain: each signal_id bit passes through NUM_SYNC_STAGES flops to give sync[i]. A history flop holds sync_1d[i].
- Event detect, evaluated per channel per cycle:
  - Mode 0: sync ^ sync_1d.
  - Mode 1: sync & ~sync_1d.
  - Mode 2: ~sync & sync_1d.
  - Mode 3: event = sync & ~sync_1d, used for sticky and counter; pulse_od = sync.
- Arming:
  - The arm counter counts from 0 to NUM_SYNC_STAGES+1, then saturates and sets armed=1.
  - While armed=0, events are suppressed: no pulse, no sticky, no count. Mode-3 pulse_od is forced to 0.
  - This prevents spurious events from inputs that are already high at reset release.
  - History flops still track sync while armed=0.
- Latency, with armed=1:
  - An input change first sampled at clk edge k drives sync at edge k+NUM_SYNC_STAGES-1.
  - The combinational event is high in the cycle after that edge.
  - REGISTER_OUTPUT=1: pulse_od goes high at edge k+NUM_SYNC_STAGES and stays high for exactly 1 cycle.
  - REGISTER_OUTPUT=0: pulse_od is high one cycle earlier, combinationally.
- Sticky flag and counter update at the same edge as the registered pulse_od, independent of REGISTER_OUTPUT.
- Counter:
  - Increments by 1 per event.
  - Saturates at 2^CNT_W-1 and never wraps.
  - cnt_sat_od = (cnt == max), registered together with cnt.
- Clear: clr_id[i] sets the channel's sticky flag and counter to 0 at the next edge.
- Clear and event in the same cycle: the event wins after the clear, giving sticky=1 and cnt=1.
- Channels are fully independent. Simultaneous events on several channels all take effect in the same cycle.
- Input changes closer together than NUM_SYNC_STAGES+1 clk cycles may merge or be lost. The sender must guarantee spacing; the block does not detect this.
- Reset asserted mid-operation clears everything immediately, and the arming window restarts on release.

Test Plan:
- Reset release with signal_id=4'b0101 held high, EDGE_MODE all rising -> no pulse_od, sticky_od=0, cnt_od=0 for all channels.
- Arming window: signal_id[0] rises 2 cycles after reset release (NUM_SYNC_STAGES=2) -> no pulse, no count.
  - Then, after arming, signal_id[0] rises -> pulse_od[0]=1 for one cycle, 2 edges after sampling.
- Toggle mode, channel 1: 5 toggles spaced 4 cycles apart -> 5 single-cycle pulses, cnt_od ch1=5, sticky_od[1]=1.
- Falling mode, channel 2: rise then fall -> exactly one pulse, on the fall; cnt=1.
- Level mode, channel 3: signal held high for 10 cycles -> pulse_od[3] high for 10 cycles, delayed by sync latency; cnt=1.
- CNT_W=4, channel 0: 20 rising events -> cnt saturates at 15, cnt_sat_od[0]=1.
  - Then clr_id[0] pulse coincident with an event -> cnt=1, sticky=1, cnt_sat_od[0]=0.
- REGISTER_OUTPUT=0 vs 1 on the same stimulus -> the pulse is 1 cycle earlier with 0; cnt_od timing is identical in both.
